// File: rtl/mmio_led_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mmio_led_ctrl                                              |
// | Description : Memory-mapped LED/GPIO controller, per-channel static,     |
// |               blink or 8-bit PWM output with a shared tick prescaler.    |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module mmio_led_ctrl #(
    parameter int          NUM_CH       = 8,
    parameter logic [31:0] BASE_ADDR    = 32'h2000,
    parameter logic [15:0] PRESCALE_RST = 16'd0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       m_addr,
    input  logic [31:0]       m_wdata,
    input  logic              wea,
    input  logic              rea,
    output logic [31:0]       m_rdata,
    output logic              rvalid,
    output logic [NUM_CH-1:0] led
);

    localparam logic [4:0] c_PRESC_IDX = 5'd16;
    localparam logic [5:0] c_NUM_CH    = 6'(NUM_CH);
    localparam logic [1:0] c_MODE_BLINK = 2'b01;
    localparam logic [1:0] c_MODE_PWM   = 2'b10;

    logic              r_level [NUM_CH];
    logic [1:0]        r_mode  [NUM_CH];
    logic [7:0]        r_duty  [NUM_CH];
    logic [15:0]       r_prescale;
    logic [15:0]       r_presc_cnt;
    logic [7:0]        r_pwm_cnt;
    logic [NUM_CH-1:0] r_led;
    logic [31:0]       r_rdata;
    logic              r_rvalid;

    logic              w_in_win;
    logic              w_aligned;
    logic [4:0]        w_idx;
    logic              w_ch_hit;
    logic              w_presc_hit;
    logic              w_tick;
    logic [31:0]       w_rdata;
    logic [NUM_CH-1:0] w_led_nxt;
    logic              w_unused;

    // The 128-byte window is decoded on the upper address bits only.
    assign w_in_win    = (m_addr[31:7] == BASE_ADDR[31:7]);
    assign w_aligned   = (m_addr[1:0] == 2'b00);
    assign w_idx       = m_addr[6:2];
    assign w_ch_hit    = w_in_win && w_aligned && ({1'b0, w_idx} < c_NUM_CH);
    assign w_presc_hit = w_in_win && w_aligned && (w_idx == c_PRESC_IDX);
    assign w_tick      = (r_presc_cnt == r_prescale);
    assign w_unused    = ^{m_wdata[31:16], m_wdata[7:3]};

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_level[i] <= 1'b0;
                r_mode[i]  <= 2'b00;
                r_duty[i]  <= 8'd0;
            end
        end else if (wea && w_ch_hit) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_idx == 5'(i)) begin
                    r_level[i] <= m_wdata[0];
                    r_mode[i]  <= m_wdata[2:1];
                    r_duty[i]  <= m_wdata[15:8];
                end
            end
        end
    end

    // A PRESCALE store restarts both counters so the new rate begins cleanly.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prescale  <= PRESCALE_RST;
            r_presc_cnt <= 16'd0;
            r_pwm_cnt   <= 8'd0;
        end else if (wea && w_presc_hit) begin
            r_prescale  <= m_wdata[15:0];
            r_presc_cnt <= 16'd0;
            r_pwm_cnt   <= 8'd0;
        end else if (w_tick) begin
            r_presc_cnt <= 16'd0;
            r_pwm_cnt   <= r_pwm_cnt + 8'd1;
        end else begin
            r_presc_cnt <= r_presc_cnt + 16'd1;
        end
    end

    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_ch_out
            always_comb begin
                case (r_mode[g])
                    c_MODE_BLINK: w_led_nxt[g] = r_pwm_cnt[7] ^ r_level[g];
                    c_MODE_PWM:   w_led_nxt[g] = (r_pwm_cnt < r_duty[g]) ^ r_level[g];
                    default:      w_led_nxt[g] = r_level[g];
                endcase
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) r_led <= '0;
        else     r_led <= w_led_nxt;
    end

    always_comb begin
        w_rdata = 32'd0;
        if (w_presc_hit) w_rdata = {16'd0, r_prescale};
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_ch_hit && (w_idx == 5'(i)))
                w_rdata = {16'd0, r_duty[i], 5'd0, r_mode[i], r_level[i]};
        end
    end

    // Read samples pre-edge register state, so a same-cycle store returns old data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata  <= 32'd0;
            r_rvalid <= 1'b0;
        end else if (rea && w_in_win) begin
            r_rdata  <= w_rdata;
            r_rvalid <= 1'b1;
        end else begin
            r_rvalid <= 1'b0;
        end
    end

    assign m_rdata = r_rdata;
    assign rvalid  = r_rvalid;
    assign led     = r_led;

endmodule
`default_nettype wire

// File: tb/tb_mmio_led_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_mmio_led_ctrl                                           |
// | Description : Self-checking bench for mmio_led_ctrl with read scoreboard |
// |               and a cycle-level reference model of the LED outputs.      |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_mmio_led_ctrl;

    localparam int NUM_CH = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [31:0]       m_addr = 32'd0;
    logic [31:0]       m_wdata = 32'd0;
    logic              wea = 1'b0;
    logic              rea = 1'b0;
    logic [31:0]       m_rdata;
    logic              rvalid;
    logic [NUM_CH-1:0] led;

    always #5 clk = ~clk;

    mmio_led_ctrl #(
        .NUM_CH       (NUM_CH),
        .BASE_ADDR    (32'h2000),
        .PRESCALE_RST (16'd0)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .wea     (wea),
        .rea     (rea),
        .m_rdata (m_rdata),
        .rvalid  (rvalid),
        .led     (led)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    endtask

    // Reference model state, advanced on each rising edge.
    logic              md_level [NUM_CH];
    logic [1:0]        md_mode  [NUM_CH];
    logic [7:0]        md_duty  [NUM_CH];
    logic [15:0]       md_pre   = 16'd0;
    logic [15:0]       md_presc = 16'd0;
    logic [7:0]        md_pwm   = 8'd0;
    logic [NUM_CH-1:0] md_led   = '0;
    logic              md_rv    = 1'b0;
    logic [31:0]       sb [$];
    logic              chk_en   = 1'b0;

    function automatic logic in_win(input logic [31:0] a);
        return (a & 32'hFFFF_FF80) == 32'h0000_2000;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        int idx;
        idx = int'(a[6:2]);
        if (a[1:0] != 2'b00) return 32'd0;
        if (idx < NUM_CH) return {16'd0, md_duty[idx], 5'd0, md_mode[idx], md_level[idx]};
        if (idx == 16) return {16'd0, md_pre};
        return 32'd0;
    endfunction

    function automatic logic chan_out(input logic lvl, input logic [1:0] md,
                                      input logic [7:0] dt, input logic [7:0] cnt);
        case (md)
            2'b01:   return cnt[7] ^ lvl;
            2'b10:   return (cnt < dt) ^ lvl;
            default: return lvl;
        endcase
    endfunction

    always @(posedge clk) begin
        logic [NUM_CH-1:0] nl;
        int idx;
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                md_level[i] = 1'b0; md_mode[i] = 2'b00; md_duty[i] = 8'd0;
            end
            md_pre = 16'd0; md_presc = 16'd0; md_pwm = 8'd0;
            md_led = '0; md_rv = 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++)
                nl[i] = chan_out(md_level[i], md_mode[i], md_duty[i], md_pwm);
            if (rea && in_win(m_addr)) begin
                sb.push_back(model_read(m_addr));
                md_rv = 1'b1;
            end else begin
                md_rv = 1'b0;
            end
            if (md_presc == md_pre) begin
                md_presc = 16'd0; md_pwm = md_pwm + 8'd1;
            end else begin
                md_presc = md_presc + 16'd1;
            end
            if (wea && in_win(m_addr) && m_addr[1:0] == 2'b00) begin
                idx = int'(m_addr[6:2]);
                if (idx < NUM_CH) begin
                    md_level[idx] = m_wdata[0];
                    md_mode[idx]  = m_wdata[2:1];
                    md_duty[idx]  = m_wdata[15:8];
                end else if (idx == 16) begin
                    md_pre = m_wdata[15:0]; md_presc = 16'd0; md_pwm = 8'd0;
                end
            end
            md_led = nl;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("led_model", 32'(led), 32'(md_led));
            check("rvalid_model", 32'(rvalid), 32'(md_rv));
            if (md_rv) begin
                if (sb.size() == 0) check("sb_underflow", 32'd1, 32'd0);
                else check("rdata_sb", m_rdata, sb.pop_front());
            end
        end
    end

    task automatic acc(input logic [31:0] a, input logic [31:0] d, input logic w, input logic r);
        m_addr = a; m_wdata = d; wea = w; rea = r;
        @(negedge clk);
        wea = 1'b0; rea = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic count_high(input int bitn, input int n, output int highs);
        highs = 0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if (led[bitn]) highs++;
        end
    endtask

    initial begin
        int highs;
        int nt;
        int tpos [3];
        logic prev;

        // reset state
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_rdata", m_rdata, 32'd0);
        check("rst_led", 32'(led), 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        rst = 1'b0;

        // static outputs and write-to-led latency
        acc(32'h2000, 32'h1, 1'b1, 1'b0);
        check("t1_led0_early", 32'(led[0]), 32'd0);
        idle(1);
        check("t1_led0", 32'(led[0]), 32'd1);
        acc(32'h201C, 32'h1, 1'b1, 1'b0);
        idle(1);
        check("t1_led81", 32'(led), 32'h81);

        // blink at PRESCALE=1: half period of 256 clocks
        acc(32'h2040, 32'h1, 1'b1, 1'b0);
        acc(32'h2004, 32'h2, 1'b1, 1'b0);
        nt = 0;
        prev = led[1];
        for (int c = 0; c < 1200 && nt < 3; c++) begin
            @(negedge clk);
            if (led[1] != prev) begin
                tpos[nt] = c;
                nt++;
                prev = led[1];
            end
        end
        check("t2_toggles", 32'(nt), 32'd3);
        if (nt == 3) begin
            check("t2_half1", 32'(tpos[1] - tpos[0]), 32'd256);
            check("t2_half2", 32'(tpos[2] - tpos[1]), 32'd256);
        end

        // PWM DUTY=0x40 at PRESCALE=0
        acc(32'h2040, 32'h0, 1'b1, 1'b0);
        acc(32'h2008, 32'h4004, 1'b1, 1'b0);
        idle(5);
        count_high(2, 256, highs);
        check("t3_duty_a", 32'(highs), 32'd64);
        nt = 0;
        prev = led[2];
        for (int c = 0; c < 600 && nt < 2; c++) begin
            @(negedge clk);
            if (led[2] && !prev) begin
                tpos[nt] = c;
                nt++;
            end
            prev = led[2];
        end
        check("t3_rises", 32'(nt), 32'd2);
        if (nt == 2) check("t3_period", 32'(tpos[1] - tpos[0]), 32'd256);

        // register reads, unmapped and out-of-window accesses
        acc(32'h2008, 32'h0, 1'b0, 1'b1);
        check("t4_rv_ch2", 32'(rvalid), 32'd1);
        check("t4_rd_ch2", m_rdata, 32'h0000_4004);
        acc(32'h2030, 32'h0, 1'b0, 1'b1);
        check("t4_rv_unmapped", 32'(rvalid), 32'd1);
        check("t4_rd_unmapped", m_rdata, 32'd0);
        acc(32'h3000, 32'h0, 1'b0, 1'b1);
        check("t4_rv_outside", 32'(rvalid), 32'd0);
        check("t4_rd_hold", m_rdata, 32'd0);
        acc(32'h200C, 32'hFFFF_FFFF, 1'b1, 1'b0);
        acc(32'h200C, 32'h0, 1'b0, 1'b1);
        check("t4_rd_masked", m_rdata, 32'h0000_FF07);
        acc(32'h2001, 32'h0, 1'b1, 1'b0);
        acc(32'h2044, 32'hFFFF, 1'b1, 1'b0);
        acc(32'h2000, 32'h0, 1'b0, 1'b1);
        check("t4_rd_misaligned_wr", m_rdata, 32'h1);
        acc(32'h2040, 32'h0, 1'b0, 1'b1);
        check("t4_rd_presc", m_rdata, 32'h0);
        acc(32'h2044, 32'h0, 1'b0, 1'b1);
        idle(4);

        // same-cycle read and write returns the old value
        acc(32'h2000, 32'h0, 1'b1, 1'b1);
        check("t5_rd_old", m_rdata, 32'h1);
        acc(32'h2000, 32'h0, 1'b0, 1'b1);
        check("t5_rd_new", m_rdata, 32'h0);

        // reset mid-PWM with a colliding store
        idle(37);
        rst = 1'b1;
        m_addr = 32'h2000; m_wdata = 32'h1; wea = 1'b1;
        @(negedge clk);
        rst = 1'b0; wea = 1'b0;
        check("t6_led_rst", 32'(led), 32'd0);
        check("t6_rv_rst", 32'(rvalid), 32'd0);
        acc(32'h2000, 32'h0, 1'b0, 1'b1);
        check("t6_store_dropped", m_rdata, 32'd0);
        acc(32'h2008, 32'h4004, 1'b1, 1'b0);
        count_high(2, 256, highs);
        check("t6_duty", 32'(highs), 32'd64);

        idle(3);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
